playback_ctrl: RTL

- User-facing playback controller that configures the mp3 streaming block: song select, pause flag and 16-bit VS1003 volume word.
- Debounces five push-buttons and auto-advances on the streamer's end-of-song flag.
- Masks the stale end-of-song flag while the streamer restarts after each song change.
- Sits between the board buttons and the mp3 block inputs (song select, pause, volume).

---
 rtl/playback_pkg.sv | 38 +++
 rtl/playback_ctrl_btn_debounce.sv | 29 ++
 rtl/playback_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/playback_pkg.sv
// Shared types and constants for the playback controller.
package playback_pkg;

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    PLAY   = 2'd1,
    PAUSE  = 2'd2,
    SETTLE = 2'd3
  } state_t;

  localparam int NUM_BTN  = 5;
  localparam int BTN_NEXT = 0;
  localparam int BTN_PREV = 1;
  localparam int BTN_PLAY = 2;
  localparam int BTN_VUP  = 3;
  localparam int BTN_VDN  = 4;

  localparam logic [7:0] VOL_BYTE_MAX = 8'hFE;
  localparam logic [7:0] VOL_BYTE_MIN = 8'h00;

  typedef struct packed {
    logic [2:0]  song;
    logic        pause;
    logic [15:0] vol;
  } play_cfg_t;

  // VS1003 volume is attenuation: louder means a smaller byte
  function automatic logic [7:0] vol_louder(input logic [7:0] b, input logic [7:0] step);
    return (b < step) ? VOL_BYTE_MIN : b - step;
  endfunction

  function automatic logic [7:0] vol_quieter(input logic [7:0] b, input logic [7:0] step);
    logic [8:0] s;
    s = {1'b0, b} + {1'b0, step};
    return (s > {1'b0, VOL_BYTE_MAX}) ? VOL_BYTE_MAX : s[7:0];
  endfunction

endpackage

// File: rtl/playback_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, one pulse per press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // counter saturates at DEBOUNCE_CYCLES so a held button fires once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], btn};
      if (!sync[1])                          cnt <= '0;
      else if (cnt != CW'(DEBOUNCE_CYCLES))  cnt <= cnt + CW'(1);
    end
  end

  assign pulse = sync[1] && (cnt == CW'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/playback_ctrl.sv
// Playback controller: buttons and end-of-song flag to song select, pause, volume.
// Optional shuffle mode on next/auto-advance: define PLAYBACK_SHUFFLE_EN.
module playback_ctrl
  import playback_pkg::*;
#(
  parameter int          SONG_NUM        = 4,
  parameter logic [15:0] VOL_INIT        = 16'h2020,
  parameter logic [7:0]  VOL_STEP        = 8'h10,
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter int          SETTLE_CYCLES   = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_btn_next,
  input  logic        i_btn_prev,
  input  logic        i_btn_play,
  input  logic        i_btn_vol_up,
  input  logic        i_btn_vol_down,
  input  logic        i_loop_all,
  input  logic        i_finish_song,
  output logic [2:0]  o_song_select,
  output logic        o_pause,
  output logic [15:0] o_vol,
  output logic [1:0]  o_state
);
  localparam int         SW   = $clog2(SETTLE_CYCLES + 1);
  localparam logic [2:0] LAST = 3'(SONG_NUM - 1);

  logic [NUM_BTN-1:0] btn_raw, btn_pls;
  logic [2:0]         fin_sr;
  logic               fin_rise;
  state_t             state, nxt_state, ret_state, nxt_ret;
  logic [SW-1:0]      settle_cnt, nxt_cnt;
  play_cfg_t          cfg, nxt_cfg;
  logic [2:0]         seq_next, seq_prev, adv;
  logic               last_stop;

  assign btn_raw = {i_btn_vol_down, i_btn_vol_up, i_btn_play, i_btn_prev, i_btn_next};

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_BTN-1:0] (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_raw),
    .pulse (btn_pls)
  );

  assign fin_rise = fin_sr[1] & ~fin_sr[2];
  assign seq_next = (cfg.song == LAST) ? 3'd0 : cfg.song + 3'd1;
  assign seq_prev = (cfg.song == 3'd0) ? LAST : cfg.song - 3'd1;

`ifdef PLAYBACK_SHUFFLE_EN
  logic [7:0] lfsr;
  logic [2:0] cand;

  if (((SONG_NUM & (SONG_NUM - 1)) != 0) || (SONG_NUM > 8)) begin : g_song_num_chk
    $error("playback_ctrl: SONG_NUM must be a power of two in 1..8 for shuffle");
  end

  // x^8+x^6+x^5+x^4+1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign cand      = lfsr[2:0] & LAST;
  assign adv       = (cand == cfg.song) ? seq_next : cand;
  assign last_stop = 1'b0;
`else
  assign adv       = seq_next;
  assign last_stop = (cfg.song == LAST) && !i_loop_all;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fin_sr     <= '0;
      state      <= STOP;
      ret_state  <= STOP;
      settle_cnt <= '0;
      cfg        <= '{song: 3'd0, pause: 1'b1, vol: VOL_INIT};
    end else begin
      fin_sr     <= {fin_sr[1:0], i_finish_song};
      state      <= nxt_state;
      ret_state  <= nxt_ret;
      settle_cnt <= nxt_cnt;
      cfg        <= nxt_cfg;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_ret   = ret_state;
    nxt_cnt   = settle_cnt;
    nxt_cfg   = cfg;
    case (state)
      STOP, PLAY, PAUSE: begin
        if (fin_rise && state == PLAY) begin
          nxt_state = SETTLE;
          if (last_stop) begin
            nxt_cfg.song  = 3'd0;
            nxt_cfg.pause = 1'b1;
            nxt_ret       = STOP;
          end else begin
            nxt_cfg.song  = adv;
            nxt_ret       = PLAY;
          end
        end else if (btn_pls[BTN_NEXT] || btn_pls[BTN_PREV]) begin
          nxt_state    = SETTLE;
          nxt_ret      = state;
          nxt_cfg.song = btn_pls[BTN_NEXT] ? adv : seq_prev;
        end else if (btn_pls[BTN_PLAY]) begin
          nxt_state     = (state == PLAY) ? PAUSE : PLAY;
          nxt_cfg.pause = (state == PLAY);
        end
      end
      SETTLE: begin
        // the streamer's finish flag is stale until it has restarted
        if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
          nxt_state = ret_state;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt   = settle_cnt + SW'(1);
        end
      end
      default: nxt_state = STOP;
    endcase

    if (btn_pls[BTN_VUP] && !btn_pls[BTN_VDN]) begin
      nxt_cfg.vol = {vol_louder(cfg.vol[15:8], VOL_STEP), vol_louder(cfg.vol[7:0], VOL_STEP)};
    end else if (btn_pls[BTN_VDN] && !btn_pls[BTN_VUP]) begin
      nxt_cfg.vol = {vol_quieter(cfg.vol[15:8], VOL_STEP), vol_quieter(cfg.vol[7:0], VOL_STEP)};
    end
  end

  assign o_song_select = cfg.song;
  assign o_pause       = cfg.pause;
  assign o_vol         = cfg.vol;
  assign o_state       = state;

endmodule
